wbc_tty_tx: RTL and testbench
=============================

Name: wbc_tty_tx

Overview:
- Debug console transmitter; the consumer end of the CPU core's tty_stb/tty_dat/tty_end debug stream.
- Buffers strobed bytes in a small synchronous FIFO and serializes them as 8N1 UART frames on a dedicated pin, e.g. a qk7_gpio1 line.
- Runs on sys_clk_p, beside the CPU wrapper, independent of the main UART.
- Signals an idle state after tty_end so benches and firmware can detect a finished, fully drained session.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW bytes (16).
- BAUD_DIV, 434, clocks per serial bit (50 MHz / 115200); legal range 2..65535.

Ports:
- clk  in  1  system clock (sys_clk_p).
- rst_n  in  1  reset: one clock; synchronous, active-low.
- tty_stb  in  1  single-cycle byte strobe from the CPU.
- tty_dat  in  8  byte value, sampled when tty_stb=1.
- tty_end  in  1  end-of-session strobe or level from the CPU.
- txd  out  1  serial output; idle level high.
- busy  out  1  FIFO non-empty or frame in progress.
- ovf  out  1  sticky: at least one byte dropped because the FIFO was full.
- done  out  1  sticky: end seen, FIFO empty and transmitter idle.

Behaviour:
- Reset (rst_n=0 at a clk edge): txd=1, busy=0, ovf=0, done=0, FIFO emptied, FSM=IDLE, end latch cleared, bit and baud counters zeroed. Reset applied mid-frame aborts the frame; txd=1 on the next edge.
- FIFO write:
  - Byte pushed at a clk edge with tty_stb=1 and not ended.
  - Push while full is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and ovf is set.
  - Pointers wrap modulo depth. Count width is FIFO_AW+1; full = count==depth.
- FSM states:
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into shift register sh[7:0], load the baud counter with BAUD_DIV-1, go to START.
  - START: txd=0 for BAUD_DIV clocks, then go to DATA with bit index=0.
  - DATA: txd=sh[0], LSB first, BAUD_DIV clocks per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV clocks. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - Strobe at edge N into an empty FIFO with the FSM in IDLE: FIFO non-empty after N; pop at N+1; txd low after edge N+2.
  - Frame length is exactly 10*BAUD_DIV clocks; back-to-back frame period is also 10*BAUD_DIV.
- Baud counter: counts down from BAUD_DIV-1 to 0; the bit transition occurs on the 0 cycle. Width is 16 bits.
- busy = (count!=0) | (state!=IDLE), registered to follow state.
- End handling:
  - tty_end=1 sets the end latch. Strobes in the same cycle as tty_end are still accepted; later strobes are ignored and do not set ovf.
  - done rises the first cycle where the end latch is set, the FIFO is empty and state=IDLE. done holds until reset.
- ovf and done clear only on reset.

Decomposition:
- Shared include (lib config/defs): FSM state encodings TX_IDLE/TX_START/TX_DATA/TX_STOP (2-bit) and the default baud divider constant.
- Sub-module wbc_fifo_sync:
  - Parameters: width=8, AW.
  - Ports: clk, rst_n, wr, wdat, rd, rdat, empty, full.
  - Registered head output, valid when !empty.
  - Reusable by a later receive path.
- Top wbc_tty_tx contains the FSM, the baud counter, and the ovf/done logic.

Test Plan (BAUD_DIV=4, FIFO_AW=2):
- Reset: hold rst_n=0 for 3 clks -> txd=1, busy=0, ovf=0, done=0. Release -> outputs unchanged with no stimulus.
- Single byte: strobe 0x55 -> txd low 2 clks later, then bits 1,0,1,0,1,0,1,0 each 4 clks, stop high 4 clks. Total 40 clks; busy drops at the end.
- Back-to-back: strobe 0xA3, 0x0F on consecutive clks -> two frames with no idle gap between stop and start; decoded 0xA3 then 0x0F.
- Overflow: 6 strobes in 6 consecutive clks (depth 4, first popped at clk+1) -> 5 bytes transmitted, 6th dropped, ovf=1 from that cycle onward.
- End drain: strobe 0x41, 0x42, then tty_end, then strobe 0x43 -> only 0x41 and 0x42 sent. done=1 one clk after the second stop bit ends; ovf stays 0.
- Mid-frame reset: rst_n=0 during DATA bit 3 of 0xFF -> txd=1 next edge, FIFO empty. After release, a new strobe 0x12 yields a clean frame.

Source files
------------

// File: rtl/wbc_tty_tx_pkg.sv
// rtl/wbc_tty_tx_pkg.sv - shared state encodings and defaults for the debug tty transmitter
// Contents: tx_state_e (2-bit FSM encoding), default baud divider and FIFO address width.
package wbc_tty_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_BAUD_DIV = 434;
    localparam int DEFAULT_FIFO_AW  = 4;

endpackage

// File: rtl/wbc_tty_tx_if.sv
// rtl/wbc_tty_tx_if.sv - CPU debug byte stream (tty_stb/tty_dat/tty_end)
// Signals: tty_stb single-cycle byte strobe, tty_dat byte value, tty_end end-of-session.
// Modports: master = CPU core side, slave = transmitter side.
interface wbc_tty_tx_if;
    logic       tty_stb;
    logic [7:0] tty_dat;
    logic       tty_end;

    modport master (output tty_stb, output tty_dat, output tty_end);
    modport slave  (input  tty_stb, input  tty_dat, input  tty_end);
endinterface

// File: rtl/wbc_fifo_sync.sv
// rtl/wbc_fifo_sync.sv - single-clock FIFO with registered head output
// Ports: clk, rst_n (sync, active-low), wr/wdat push, rd pop,
//        rdat head of queue (valid while !empty), empty, full.
// A push while full is taken only when a pop happens in the same cycle.
module wbc_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdat,
    input  logic             rd,
    output logic [WIDTH-1:0] rdat,
    output logic             empty,
    output logic             full
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             wr_ok, rd_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign rdat  = head_q;

    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // The new head is the byte being written when it lands in the slot
        // the read pointer will point at (queue was empty or drains to it).
        if (wr_ok && (wr_ptr_q == rd_ptr_d)) head_d = wdat;
        else                                 head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wdat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/wbc_tty_tx.sv
// rtl/wbc_tty_tx.sv - debug console 8N1 transmitter fed by the CPU tty stream
// Ports: clk, rst_n (sync, active-low), tty (stream slave: tty_stb/tty_dat/tty_end),
//        txd serial out (idle high), busy, ovf (sticky drop), done (sticky drained end).
module wbc_tty_tx
    import wbc_tty_tx_pkg::*;
#(
    parameter int FIFO_AW  = DEFAULT_FIFO_AW,
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic          clk,
    input  logic          rst_n,
    wbc_tty_tx_if.slave   tty,
    output logic          txd,
    output logic          busy,
    output logic          ovf,
    output logic          done
);
    localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        end_q, end_d;

    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_rdat;
    logic        push, pop, bit_done;

    // Strobes arriving with tty_end are still taken; end_q gates later ones.
    assign push     = tty.tty_stb & ~end_q;
    assign bit_done = (baud_q == 16'd0);
    // Pop from IDLE, or at the last stop-bit cycle to chain frames with no gap.
    assign pop      = ~fifo_empty & ((state_q == TX_IDLE) |
                                     ((state_q == TX_STOP) & bit_done));

    wbc_fifo_sync #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push),
        .wdat  (tty.tty_dat),
        .rd    (pop),
        .rdat  (fifo_rdat),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        end_d   = end_q | tty.tty_end;
        ovf_d   = ovf_q | (push & fifo_full & ~pop);
        done_d  = done_q | (end_q & fifo_empty & (state_q == TX_IDLE));
        busy_d  = ~fifo_empty | (state_q != TX_IDLE);

        // txd is registered from the current state, so the line trails the
        // FSM by one clock; every bit still lasts exactly BAUD_DIV clocks.
        case (state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = sh_q[0];
            default:  txd_d = 1'b1;
        endcase

        case (state_q)
            TX_IDLE: begin
                if (pop) begin
                    sh_d    = fifo_rdat;
                    baud_d  = BAUD_LOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    baud_d = BAUD_LOAD;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (pop) begin
                        sh_d    = fifo_rdat;
                        baud_d  = BAUD_LOAD;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            end_q   <= end_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: tb/tb_wbc_tty_tx.sv
// tb/tb_wbc_tty_tx.sv - self-checking bench for wbc_tty_tx (BAUD_DIV=4, FIFO_AW=2)
module tb_wbc_tty_tx;
    localparam int BAUD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic txd, busy, ovf, done;

    wbc_tty_tx_if tty_if ();

    wbc_tty_tx #(.FIFO_AW(2), .BAUD_DIV(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tty   (tty_if),
        .txd   (txd),
        .busy  (busy),
        .ovf   (ovf),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dat;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] rxq [$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tty_if.tty_stb = 1'b0;
        tty_if.tty_end = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Returns just after the sampling edge N.
    task automatic strobe(input logic [7:0] d);
        tty_if.tty_stb = 1'b1;
        tty_if.tty_dat = d;
        tick(1);
        tty_if.tty_stb = 1'b0;
    endtask

    // Entered at the middle of the first start bit (edge N+3 for a strobe at N);
    // samples back-to-back frames and returns at the middle of the last stop bit.
    task automatic capture(input int nfr, input string name);
        logic [9:0] fr;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 10; k++) begin
                fr[k] = txd;
                if (!(f == nfr - 1 && k == 9)) tick(BAUD);
            end
            chk($sformatf("%s_f%0d_start", name, f), {31'd0, fr[0]}, 32'd0);
            chk($sformatf("%s_f%0d_stop", name, f), {31'd0, fr[9]}, 32'd1);
            rxq.push_back(fr[8:1]);
        end
    endtask

    task automatic send_and_check(input logic [7:0] d, input logic [9:0] frame, input string name);
        strobe(d);
        tick(1);
        chk({name, "_lat1"}, {31'd0, txd}, 32'd1);
        tick(1);
        chk({name, "_lat2"}, {31'd0, txd}, 32'd0);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_bit%0d", name, k), {31'd0, txd}, {31'd0, frame[k]});
            if (k < 9) tick(BAUD);
        end
        tick(2);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd1);
        tick(1);
        chk({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({name, "_txd_idle"}, {31'd0, txd}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{dat: 8'h55, frame: 10'b1010101010};
        vecs[1] = '{dat: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{dat: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{dat: 8'h80, frame: 10'b1100000000};
        vecs[4] = '{dat: 8'h01, frame: 10'b1000000010};

        tty_if.tty_stb = 1'b0;
        tty_if.tty_dat = 8'h00;
        tty_if.tty_end = 1'b0;

        // Reset state, then quiet after release
        rst_n = 1'b0;
        tick(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("rel_txd", {31'd0, txd}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_ovf", {31'd0, ovf}, 32'd0);
        chk("rel_done", {31'd0, done}, 32'd0);

        // Single-byte frames from the table
        for (int i = 0; i < 5; i++) begin
            send_and_check(vecs[i].dat, vecs[i].frame, $sformatf("vec%0d", i));
            tick(2);
        end

        // Back-to-back: no idle gap between frames
        rxq.delete();
        strobe(8'hA3);
        strobe(8'h0F);
        tick(2);
        capture(2, "b2b");
        chk("b2b_n", rxq.size(), 32'd2);
        chk("b2b_b0", {24'd0, rxq[0]}, 32'hA3);
        chk("b2b_b1", {24'd0, rxq[1]}, 32'h0F);
        tick(2);
        chk("b2b_busy_end", {31'd0, busy}, 32'd1);
        tick(1);
        chk("b2b_busy_drop", {31'd0, busy}, 32'd0);

        // Overflow: six strobes into a four-deep FIFO
        do_reset();
        rxq.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    strobe(8'h31 + 8'(i));
                    if (i == 4) chk("ovf_before", {31'd0, ovf}, 32'd0);
                    if (i == 5) chk("ovf_set", {31'd0, ovf}, 32'd1);
                end
            end
            begin
                tick(4);
                capture(5, "ovf");
            end
        join
        chk("ovf_n", rxq.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("ovf_b%0d", i), {24'd0, rxq[i]}, 32'h31 + i);
        tick(2);
        chk("ovf_busy_end", {31'd0, busy}, 32'd1);
        tick(1);
        chk("ovf_busy_drop", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // End drain: strobe after tty_end is ignored, done after drain
        do_reset();
        rxq.delete();
        fork
            begin
                strobe(8'h41);
                strobe(8'h42);
                tty_if.tty_end = 1'b1;
                tick(1);
                tty_if.tty_end = 1'b0;
                strobe(8'h43);
            end
            begin
                tick(4);
                capture(2, "end");
            end
        join
        chk("end_n", rxq.size(), 32'd2);
        chk("end_b0", {24'd0, rxq[0]}, 32'h41);
        chk("end_b1", {24'd0, rxq[1]}, 32'h42);
        tick(2);
        chk("end_done_early", {31'd0, done}, 32'd0);
        chk("end_busy_end", {31'd0, busy}, 32'd1);
        tick(1);
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_busy_drop", {31'd0, busy}, 32'd0);
        chk("end_ovf", {31'd0, ovf}, 32'd0);
        strobe(8'h44);
        tick(5);
        chk("end_post_busy", {31'd0, busy}, 32'd0);
        chk("end_post_txd", {31'd0, txd}, 32'd1);
        chk("end_post_done", {31'd0, done}, 32'd1);
        chk("end_post_ovf", {31'd0, ovf}, 32'd0);

        // Mid-frame reset during data bit 3 of 0xFF
        do_reset();
        strobe(8'hFF);
        tick(19);
        chk("mrst_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_txd", {31'd0, txd}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(8);
        chk("mrst_quiet_txd", {31'd0, txd}, 32'd1);
        chk("mrst_quiet_busy", {31'd0, busy}, 32'd0);
        send_and_check(8'h12, 10'b1000100100, "mrst_x12");
        chk("mrst_ovf", {31'd0, ovf}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
